// File: rtl/sweep_step_sequencer.sv
// Ping-pong angle sweep sequencer: dwell at each bin, request one sample with
// req/ack and timeout, then issue exactly one step toward the next bin.
module sweep_step_sequencer #(
  parameter int unsigned ANGLE_STEPS    = 180,
  parameter int unsigned DWELL_CYCLES   = 100000,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sample_ack,
  output logic        step_pulse,
  output logic        step_dir,
  output logic        sample_req,
  output logic [15:0] pos_idx,
  output logic        sweep_done,
  output logic [15:0] sweep_count,
  output logic        sample_timeout,
  output logic        busy
);

  localparam int unsigned PW = $clog2(ANGLE_STEPS);
  localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DWELL  = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_STEP   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [PW-1:0] pos_q, pos_d, pos_step, pos_end;
  logic          dir_d;
  logic          step_pulse_d, sample_req_d, sweep_done_d, timeout_d, busy_d;
  logic [15:0]   count_d;

  assign pos_idx = 16'(pos_q);

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      dwell_q        <= '0;
      tmo_q          <= '0;
      pos_q          <= '0;
      step_dir       <= 1'b1;
      step_pulse     <= 1'b0;
      sample_req     <= 1'b0;
      sweep_done     <= 1'b0;
      sweep_count    <= 16'd0;
      sample_timeout <= 1'b0;
      busy           <= 1'b0;
    end else begin
      state_q        <= state_d;
      dwell_q        <= dwell_d;
      tmo_q          <= tmo_d;
      pos_q          <= pos_d;
      step_dir       <= dir_d;
      step_pulse     <= step_pulse_d;
      sample_req     <= sample_req_d;
      sweep_done     <= sweep_done_d;
      sweep_count    <= count_d;
      sample_timeout <= timeout_d;
      busy           <= busy_d;
    end
  end

  // Next-state and next-output logic; the step target is precomputed so the
  // new position and end-bin flag are visible during the STEP cycle itself.
  always_comb begin
    state_d      = state_q;
    dwell_d      = dwell_q;
    tmo_d        = tmo_q;
    pos_d        = pos_q;
    dir_d        = step_dir;
    step_pulse_d = 1'b0;
    sample_req_d = 1'b0;
    sweep_done_d = 1'b0;
    count_d      = sweep_count;
    timeout_d    = sample_timeout;
    pos_step     = step_dir ? (pos_q + PW'(1)) : (pos_q - PW'(1));
    pos_end      = step_dir ? PW'(ANGLE_STEPS - 1) : '0;

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_d = S_DWELL;
          dwell_d = DW'(DWELL_CYCLES - 1);
        end
      end
      S_DWELL: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else if (dwell_q == '0) begin
          state_d      = S_SAMPLE;
          sample_req_d = 1'b1;
          tmo_d        = TW'(TIMEOUT_CYCLES - 1);
        end else begin
          dwell_d = dwell_q - DW'(1);
        end
      end
      S_SAMPLE: begin
        if (sample_ack || (tmo_q == '0)) begin
          if (!sample_ack) timeout_d = 1'b1;
          state_d      = S_STEP;
          step_pulse_d = 1'b1;
          pos_d        = pos_step;
          if (pos_step == pos_end) begin
            sweep_done_d = 1'b1;
            if (sweep_count != 16'hFFFF) count_d = sweep_count + 16'd1;
          end
        end else begin
          tmo_d = tmo_q - TW'(1);
        end
      end
      S_STEP: begin
        // Reverse only after the end-bin step has been presented
        if (sweep_done) dir_d = ~step_dir;
        if (enable) begin
          state_d = S_DWELL;
          dwell_d = DW'(DWELL_CYCLES - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

endmodule

// File: tb/tb_sweep_step_sequencer.sv
// Directed bench for sweep_step_sequencer with ANGLE_STEPS=4, DWELL_CYCLES=4,
// TIMEOUT_CYCLES=8; expected values are hand-derived cycle counts and positions.
module tb_sweep_step_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable = 1'b0;
  logic        ack_auto = 1'b0;
  logic        ack_force = 1'b0;
  logic        sample_ack;
  logic        step_pulse, step_dir, sample_req, sweep_done, sample_timeout, busy;
  logic [15:0] pos_idx, sweep_count;

  int checks = 0;
  int errors = 0;

  // Optional auto-ack on the sample_req cycle, plus a directly forced ack
  assign sample_ack = (ack_auto & sample_req) | ack_force;

  always #5 clk = ~clk;

  sweep_step_sequencer #(
    .ANGLE_STEPS(4),
    .DWELL_CYCLES(4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .sample_ack(sample_ack),
    .step_pulse(step_pulse),
    .step_dir(step_dir),
    .sample_req(sample_req),
    .pos_idx(pos_idx),
    .sweep_done(sweep_done),
    .sweep_count(sweep_count),
    .sample_timeout(sample_timeout),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_step(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!step_pulse && n < max);
    if (!step_pulse) check("step_wait_expired", 32'(n), 32'(max + 1));
  endtask

  task automatic wait_req(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!sample_req && n < max);
    if (!sample_req) check("req_wait_expired", 32'(n), 32'(max + 1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pos"}, 32'(pos_idx), 0);
    check({tag, "_dir"}, 32'(step_dir), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_count"}, 32'(sweep_count), 0);
    check({tag, "_strobes"}, 32'({step_pulse, sample_req, sweep_done}), 0);
    check({tag, "_timeout"}, 32'(sample_timeout), 0);
  endtask

  int exp_pos[7]  = '{1, 2, 3, 2, 1, 0, 1};
  int exp_dir[7]  = '{1, 1, 1, 0, 0, 0, 1};
  int exp_done[7] = '{0, 0, 1, 0, 0, 1, 0};
  int exp_cnt[7]  = '{0, 0, 1, 1, 1, 2, 2};

  initial begin
    int n;
    int strays;

    // Reset asserted with no clock edge in between
    #1 rst_n = 1'b0;
    #1 check_reset_values("rst_async");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Continuous ping-pong with ack on the request cycle
    enable   = 1'b1;
    ack_auto = 1'b1;
    for (int i = 0; i < 7; i++) begin
      wait_step(20, n);
      check($sformatf("gap%0d", i), 32'(n), (i == 3) ? 32'd5 : 32'd6);
      check($sformatf("pos%0d", i), 32'(pos_idx), 32'(exp_pos[i]));
      check($sformatf("dir%0d", i), 32'(step_dir), 32'(exp_dir[i]));
      check($sformatf("done%0d", i), 32'(sweep_done), 32'(exp_done[i]));
      check($sformatf("count%0d", i), 32'(sweep_count), 32'(exp_cnt[i]));
      check($sformatf("range%0d", i), 32'(pos_idx <= 16'd3), 1);
      if (i == 2) begin
        @(negedge clk);
        check("dir_after_end", 32'(step_dir), 0);
      end
    end

    // Ack never arrives: eight SAMPLE cycles then STEP
    ack_auto = 1'b0;
    wait_req(20, n);
    check("req_latency", 32'(n), 5);
    check("timeout_before", 32'(sample_timeout), 0);
    wait_step(20, n);
    check("timeout_gap", 32'(n), 8);
    check("timeout_flag", 32'(sample_timeout), 1);
    check("timeout_pos", 32'(pos_idx), 2);
    ack_auto = 1'b1;
    wait_step(20, n);
    check("acked_gap", 32'(n), 6);
    check("acked_pos", 32'(pos_idx), 3);
    check("timeout_sticky", 32'(sample_timeout), 1);

    // Drop enable on the second DWELL cycle
    @(negedge clk);
    check("dir_flip2", 32'(step_dir), 0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_idle", 32'(busy), 0);
    strays = 0;
    repeat (8) begin
      @(negedge clk);
      if (step_pulse || sample_req || busy) strays++;
    end
    check("abort_quiet", 32'(strays), 0);
    check("abort_pos", 32'(pos_idx), 3);
    check("abort_dir", 32'(step_dir), 0);
    enable = 1'b1;
    wait_step(20, n);
    check("resume_gap", 32'(n), 6);
    check("resume_pos", 32'(pos_idx), 2);
    check("resume_dir", 32'(step_dir), 0);

    // Drop enable inside SAMPLE: the step still happens, then IDLE
    ack_auto = 1'b0;
    wait_req(20, n);
    check("req_latency2", 32'(n), 5);
    enable = 1'b0;
    @(negedge clk);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    check("sample_drop_step", 32'(step_pulse), 1);
    check("sample_drop_pos", 32'(pos_idx), 1);
    @(negedge clk);
    check("sample_drop_idle", 32'(busy), 0);

    // Stray acks in IDLE and DWELL are ignored
    ack_force = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ack_busy", 32'(busy), 0);
    check("idle_ack_pos", 32'(pos_idx), 1);
    ack_force = 1'b0;
    enable = 1'b1;
    @(negedge clk);
    @(negedge clk);
    ack_force = 1'b1;
    @(negedge clk);
    ack_force = 1'b0;
    check("dwell_ack_nostep", 32'(step_pulse), 0);
    wait_req(20, n);
    check("dwell_ack_req", 32'(n), 2);

    // Reset in the middle of SAMPLE
    @(negedge clk);
    check("mid_sample_busy", 32'(busy), 1);
    #1 rst_n = 1'b0;
    #1 check_reset_values("rst_mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
